sdram_cmd_gen: RTL and testbench
================================

Name: sdram_cmd_gen

Overview:
Parametrised successor to the fixed-geometry SDRAM command stage. It owns the whole command path in one block: power-up init sequencer, work FSM, auto-refresh timer, request handshake and registered pin drive. Bank/row/column widths, CAS latency, burst length, timing and precharge mode are set by parameters instead of hard-coded values. It sits between the system read/write arbiter and the SDRAM pads; the data path uses rd_strobe and wr_strobe to align with the pins.

Parameters:
BA_W, 2, bank address bits
ROW_W, 13, row bits (>=11)
COL_W, 9, column bits (<=10)
CL, 3, CAS latency (2 or 3)
BL, 8, burst length (1,2,4,8)
T_POWERUP, 20000, NOP cycles after reset before init PRECHARGE
T_RP, 2; T_RCD, 2; T_RFC, 7; T_MRD, 2; T_WR, 2, timing in clk cycles (each >=1)
INIT_REF, 2, AUTO REFRESH count during init (>=1)
REF_INTERVAL, 780, cycles between refresh requests
AUTO_PRE, 1, 1 = A10 auto-precharge on RD/WR; 0 = explicit PRECHARGE after access

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  access request
req_ready  out  1  request accepted when req_valid&&req_ready
req_wr  in  1  1=write, 0=read; sampled at accept
req_addr  in  BA_W+ROW_W+COL_W  {bank,row,col}; sampled at accept
done  out  1  one-cycle pulse when an access fully completes
init_done  out  1  high from the end of init until reset
rd_strobe  out  1  read data valid on DQ this cycle
wr_strobe  out  1  drive write data on DQ this cycle
sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen  out  1 each  command pins
sdram_ba  out  BA_W  bank
sdram_addr  out  ROW_W  address

Behaviour:
- Command encoding {cke,csn,rasn,casn,wen}: NOP 10111, ACTIVE 10011, READ 10101, WRITE 10100, PRECHARGE 10010, A_REF 10001, LMR 10000.
- Reset values: pins = NOP, ba=0, addr=0; req_ready, done, init_done, rd_strobe and wr_strobe = 0; FSM returns to I_WAIT; refresh counter and pending flag cleared.
- All pin outputs are registered. A command appears on the pins exactly 1 cycle after its FSM state is entered. Pins carry NOP with ba/addr=0 in every non-command state.
- Init FSM: I_WAIT (T_POWERUP cycles) -> I_PRE (PRECHARGE, A10=1) -> I_TRP (T_RP) -> I_REF (A_REF) -> I_TRFC (T_RFC), repeated INIT_REF times -> I_MRS (LMR, ba=0).
  - LMR addr: all zero except A6:4=CL and A2:0=log2(BL); A3=0 (sequential), A9=0, A8:7=00.
  - I_MRS -> I_TMRD (T_MRD) -> IDLE; init_done rises on entering IDLE.
- Refresh timer:
  - Runs only when init_done=1.
  - Counts REF_INTERVAL-1 down to 0, then reloads and sets ref_pend.
  - ref_pend is cleared on entry to REF.
  - If the timer expires while REF is being entered, ref_pend stays set.
- IDLE:
  - req_ready = init_done && !ref_pend && state==IDLE (combinational).
  - ref_pend has priority: IDLE -> REF (A_REF) -> TRFC (T_RFC) -> IDLE, even when req_valid=1 in the same cycle.
  - Otherwise an accept latches addr/wr and goes to ACT.
- Access:
  - ACT: ACTIVE with ba=bank, addr=row.
  - TRCD: T_RCD-1 NOP cycles (0 if T_RCD=1).
  - RD or WR command: ba=bank; addr = column zero-extended to 10 bits, A10=AUTO_PRE, upper bits 0.
- Read: READ -> CLW (CL-1) -> RDATA (BL). rd_strobe is high for BL cycles, starting CL cycles after READ is on the pins.
- Write: WRITE -> WDATA (BL-1) -> TWR (T_WR). wr_strobe is high for BL cycles, starting in the same cycle WRITE is on the pins.
- Completion:
  - AUTO_PRE=1: TRP wait (T_RP) -> IDLE.
  - AUTO_PRE=0: PRE (PRECHARGE, ba=bank, A10=0) -> TRP (T_RP) -> IDLE.
  - done pulses in the cycle IDLE is re-entered from TRP.
- One shared down-counter serves all waits. Each wait state lasts exactly its parameter count.
- Reset asserted mid-access: pins go to NOP immediately (async). Strobes drop, the access is lost (no done), and init reruns in full.

Test Plan:
- Init, T_POWERUP=10, INIT_REF=2, CL=3, BL=8 -> 10 NOPs, PRECHARGE addr=0x0400, 2x(A_REF + 7 NOPs), LMR addr=0x0033 ba=0, init_done high after T_MRD.
- Read, AUTO_PRE=1, req_addr={2'd1,13'h0ABC,9'h015}, accept at cycle 0 -> ACTIVE ba=1 addr=0x0ABC at cycle 1, READ addr=0x0415 at cycle 3, rd_strobe cycles 6-13, done once, req_ready low throughout.
- Write, AUTO_PRE=0, same address -> WRITE addr=0x0015, wr_strobe 8 cycles starting with WRITE, PRECHARGE ba=1 addr=0 after T_WR, done after T_RP.
- REF_INTERVAL=50, req_valid held high continuously -> A_REF issued every 50 cycles whenever the FSM is in IDLE; no request accepted while ref_pend=1; no ACTIVE inside any T_RFC window.
- Timer expiry during a write burst -> burst completes, then A_REF precedes the next ACTIVE.
- rst pulsed during RDATA -> pins NOP next edge, rd_strobe=0, init_done=0, no done pulse, full init sequence repeats.

Source files
------------

// File: rtl/sdram_cmd_gen_if.sv
// -----------------------------------------------------------------------------
// sdram_cmd_gen_if
// Groups the SDRAM command generator's request handshake, status outputs and
// SDRAM command pins into one bundle.
//   master : arbiter / pad side. Drives req_valid, req_wr, req_addr. Observes
//            everything else.
//   slave  : the command generator. Drives req_ready, done, init_done,
//            rd_strobe, wr_strobe and the sdram_* pins.
// req_addr is packed as {bank, row, col}.
// -----------------------------------------------------------------------------
interface sdram_cmd_gen_if #(
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_wr;
    logic [BA_W+ROW_W+COL_W-1:0]  req_addr;
    logic                         done;
    logic                         init_done;
    logic                         rd_strobe;
    logic                         wr_strobe;
    logic                         sdram_cke;
    logic                         sdram_csn;
    logic                         sdram_rasn;
    logic                         sdram_casn;
    logic                         sdram_wen;
    logic [BA_W-1:0]              sdram_ba;
    logic [ROW_W-1:0]             sdram_addr;

    modport master (
        output req_valid, req_wr, req_addr,
        input  req_ready, done, init_done, rd_strobe, wr_strobe,
        input  sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen,
        input  sdram_ba, sdram_addr
    );

    modport slave (
        input  req_valid, req_wr, req_addr,
        output req_ready, done, init_done, rd_strobe, wr_strobe,
        output sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen,
        output sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_cmd_gen.sv
// -----------------------------------------------------------------------------
// sdram_cmd_gen
// Complete SDRAM command path. It contains the power-up init sequencer, the
// access FSM, the auto-refresh timer, the request handshake and the registered
// command pins. Geometry, CAS latency, burst length, timing and precharge mode
// are all set by parameters.
//
// Ports
//   clk   : clock
//   rst   : asynchronous reset, active-high
//   bus   : sdram_cmd_gen_if.slave
//           req_valid/req_ready/req_wr/req_addr : request handshake
//           done      : one-cycle pulse when an access completes
//           init_done : high once init has finished
//           rd_strobe : read data valid on DQ this cycle
//           wr_strobe : drive write data on DQ this cycle
//           sdram_*   : registered command, bank and address pins
//
// Pin outputs are decoded from the next state and then registered. As a
// result, the command for a state is on the pins for the whole time the FSM
// sits in that state.
// -----------------------------------------------------------------------------
module sdram_cmd_gen #(
    parameter int BA_W         = 2,
    parameter int ROW_W        = 13,
    parameter int COL_W        = 9,
    parameter int CL           = 3,
    parameter int BL           = 8,
    parameter int T_POWERUP    = 20000,
    parameter int T_RP         = 2,
    parameter int T_RCD        = 2,
    parameter int T_RFC        = 7,
    parameter int T_MRD        = 2,
    parameter int T_WR         = 2,
    parameter int INIT_REF     = 2,
    parameter int REF_INTERVAL = 780,
    parameter int AUTO_PRE     = 1
) (
    input  logic           clk,
    input  logic           rst,
    sdram_cmd_gen_if.slave bus
);
    localparam int ADDR_W = BA_W + ROW_W + COL_W;

    // {cke, csn, rasn, casn, wen}
    localparam logic [4:0] CMD_NOP  = 5'b10111;
    localparam logic [4:0] CMD_ACT  = 5'b10011;
    localparam logic [4:0] CMD_RD   = 5'b10101;
    localparam logic [4:0] CMD_WR   = 5'b10100;
    localparam logic [4:0] CMD_PRE  = 5'b10010;
    localparam logic [4:0] CMD_AREF = 5'b10001;
    localparam logic [4:0] CMD_LMR  = 5'b10000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_int(max_int(max_int(T_POWERUP, T_RFC), max_int(T_RP, T_RCD)),
                                     max_int(max_int(T_MRD, T_WR), max_int(CL, BL)));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(REF_INTERVAL + 1);
    localparam int IR_W    = $clog2(INIT_REF + 1);

    // Counter load values: a wait state lasting N cycles is loaded with N-1.
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] LD_RP      = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC     = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LD_MRD     = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_WR      = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] LD_RCD     = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CNT_W-1:0] LD_CLW     = CNT_W'(CL - 2);
    localparam logic [CNT_W-1:0] LD_RDATA   = CNT_W'(BL - 1);
    localparam logic [CNT_W-1:0] LD_WDATA   = CNT_W'((BL > 1) ? BL - 2 : 0);
    localparam logic [TMR_W-1:0] LD_REF_TMR = TMR_W'(REF_INTERVAL - 1);
    localparam logic [IR_W-1:0]  LAST_IREF  = IR_W'(INIT_REF - 1);

    typedef enum logic [4:0] {
        I_WAIT, I_PRE, I_TRP, I_REF, I_TRFC, I_MRS, I_TMRD,
        IDLE, REF, TRFC,
        ACT, TRCD, RD, CLW, RDATA, WR, WDATA, TWR, PRE, TRP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IR_W-1:0]      iref_reg, iref_next;
    logic [TMR_W-1:0]     ref_timer_reg, ref_timer_next;
    logic                 ref_pend_reg, ref_pend_next;
    logic                 init_done_reg, init_done_next;
    logic [ADDR_W-1:0]    acc_addr_reg, acc_addr_next;
    logic                 acc_wr_reg, acc_wr_next;
    logic [4:0]           cmd_reg, cmd_next;
    logic [BA_W-1:0]      ba_reg, ba_next;
    logic [ROW_W-1:0]     addr_reg, addr_next;
    logic                 rd_strobe_reg, rd_strobe_next;
    logic                 wr_strobe_reg, wr_strobe_next;
    logic                 done_reg, done_next;

    logic                 cnt_zero;
    logic                 req_ready;
    logic                 accept;
    logic [BA_W-1:0]      acc_bank;
    logic [COL_W-1:0]     acc_col;

    assign cnt_zero  = (cnt_reg == '0);
    assign req_ready = init_done_reg && !ref_pend_reg && (state_reg == IDLE);
    assign accept    = req_ready && bus.req_valid;
    assign acc_bank  = acc_addr_reg[ADDR_W-1 -: BA_W];
    assign acc_col   = acc_addr_reg[COL_W-1:0];

    function automatic logic [CNT_W-1:0] wait_len(input state_t s);
        case (s)
            I_WAIT:      return LD_POWERUP;
            I_TRP, TRP:  return LD_RP;
            I_TRFC, TRFC: return LD_RFC;
            I_TMRD:      return LD_MRD;
            TRCD:        return LD_RCD;
            CLW:         return LD_CLW;
            RDATA:       return LD_RDATA;
            WDATA:       return LD_WDATA;
            TWR:         return LD_WR;
            default:     return '0;
        endcase
    endfunction

    // State and pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= I_WAIT;
            cnt_reg       <= LD_POWERUP;
            iref_reg      <= '0;
            ref_timer_reg <= LD_REF_TMR;
            ref_pend_reg  <= 1'b0;
            init_done_reg <= 1'b0;
            acc_addr_reg  <= '0;
            acc_wr_reg    <= 1'b0;
            cmd_reg       <= CMD_NOP;
            ba_reg        <= '0;
            addr_reg      <= '0;
            rd_strobe_reg <= 1'b0;
            wr_strobe_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            iref_reg      <= iref_next;
            ref_timer_reg <= ref_timer_next;
            ref_pend_reg  <= ref_pend_next;
            init_done_reg <= init_done_next;
            acc_addr_reg  <= acc_addr_next;
            acc_wr_reg    <= acc_wr_next;
            cmd_reg       <= cmd_next;
            ba_reg        <= ba_next;
            addr_reg      <= addr_next;
            rd_strobe_reg <= rd_strobe_next;
            wr_strobe_reg <= wr_strobe_next;
            done_reg      <= done_next;
        end
    end

    // Next state, shared wait counter, refresh timer and request capture
    always_comb begin
        state_next     = state_reg;
        iref_next      = iref_reg;
        acc_addr_next  = acc_addr_reg;
        acc_wr_next    = acc_wr_reg;

        case (state_reg)
            I_WAIT: if (cnt_zero) state_next = I_PRE;
            I_PRE:  state_next = I_TRP;
            I_TRP:  if (cnt_zero) state_next = I_REF;
            I_REF:  state_next = I_TRFC;
            I_TRFC: begin
                if (cnt_zero) begin
                    if (iref_reg == LAST_IREF) begin
                        state_next = I_MRS;
                    end else begin
                        state_next = I_REF;
                        iref_next  = iref_reg + IR_W'(1);
                    end
                end
            end
            I_MRS:  state_next = I_TMRD;
            I_TMRD: if (cnt_zero) state_next = IDLE;
            IDLE: begin
                // A pending refresh wins over a simultaneous request.
                if (ref_pend_reg) begin
                    state_next = REF;
                end else if (accept) begin
                    state_next    = ACT;
                    acc_addr_next = bus.req_addr;
                    acc_wr_next   = bus.req_wr;
                end
            end
            REF:    state_next = TRFC;
            TRFC:   if (cnt_zero) state_next = IDLE;
            ACT: begin
                if (T_RCD > 1)       state_next = TRCD;
                else if (acc_wr_reg) state_next = WR;
                else                 state_next = RD;
            end
            TRCD:   if (cnt_zero) state_next = acc_wr_reg ? WR : RD;
            RD:     state_next = CLW;
            CLW:    if (cnt_zero) state_next = RDATA;
            RDATA:  if (cnt_zero) state_next = (AUTO_PRE != 0) ? TRP : PRE;
            WR:     state_next = (BL > 1) ? WDATA : TWR;
            WDATA:  if (cnt_zero) state_next = TWR;
            TWR:    if (cnt_zero) state_next = (AUTO_PRE != 0) ? TRP : PRE;
            PRE:    state_next = TRP;
            TRP:    if (cnt_zero) state_next = IDLE;
            default: state_next = I_WAIT;
        endcase

        // Every state change reloads the counter for the state being entered.
        if (state_next != state_reg) begin
            cnt_next = wait_len(state_next);
        end else if (!cnt_zero) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end else begin
            cnt_next = cnt_reg;
        end

        init_done_next = init_done_reg || ((state_reg == I_TMRD) && (state_next == IDLE));

        // The timer is free-running once init is done. An expiry on the same
        // edge that REF is entered must leave the request pending.
        ref_timer_next = ref_timer_reg;
        ref_pend_next  = ref_pend_reg;
        if ((state_reg == IDLE) && (state_next == REF)) begin
            ref_pend_next = 1'b0;
        end
        if (init_done_reg) begin
            if (ref_timer_reg == '0) begin
                ref_timer_next = LD_REF_TMR;
                ref_pend_next  = 1'b1;
            end else begin
                ref_timer_next = ref_timer_reg - TMR_W'(1);
            end
        end
    end

    // Pin decode from the next state. ACT is only ever entered from IDLE on
    // the edge that captures the request, so its bank/row come straight from
    // the bus rather than from the capture register.
    always_comb begin
        cmd_next       = CMD_NOP;
        ba_next        = '0;
        addr_next      = '0;
        rd_strobe_next = (state_next == RDATA);
        wr_strobe_next = (state_next == WR) || (state_next == WDATA);
        done_next      = (state_reg == TRP) && (state_next == IDLE);

        case (state_next)
            I_PRE: begin
                cmd_next      = CMD_PRE;
                addr_next[10] = 1'b1;
            end
            I_REF, REF: cmd_next = CMD_AREF;
            I_MRS: begin
                cmd_next       = CMD_LMR;
                addr_next[6:4] = 3'(CL);
                addr_next[2:0] = 3'($clog2(BL));
            end
            ACT: begin
                cmd_next  = CMD_ACT;
                ba_next   = bus.req_addr[ADDR_W-1 -: BA_W];
                addr_next = bus.req_addr[COL_W +: ROW_W];
            end
            RD, WR: begin
                cmd_next             = (state_next == WR) ? CMD_WR : CMD_RD;
                ba_next              = acc_bank;
                addr_next[COL_W-1:0] = acc_col;
                addr_next[10]        = (AUTO_PRE != 0);
            end
            PRE: begin
                cmd_next = CMD_PRE;
                ba_next  = acc_bank;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.done       = done_reg;
    assign bus.init_done  = init_done_reg;
    assign bus.rd_strobe  = rd_strobe_reg;
    assign bus.wr_strobe  = wr_strobe_reg;
    assign bus.sdram_cke  = cmd_reg[4];
    assign bus.sdram_csn  = cmd_reg[3];
    assign bus.sdram_rasn = cmd_reg[2];
    assign bus.sdram_casn = cmd_reg[1];
    assign bus.sdram_wen  = cmd_reg[0];
    assign bus.sdram_ba   = ba_reg;
    assign bus.sdram_addr = addr_reg;
endmodule

// File: tb/tb_sdram_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_gen
// Directed bench with two generator instances that share clk and rst:
//   dut_a : AUTO_PRE=1, REF_INTERVAL=780 (read path, reset mid-read)
//   dut_b : AUTO_PRE=0, REF_INTERVAL=50  (write path, refresh interaction)
// Both use T_POWERUP=10 and the default timing. The variable k counts
// rising edges since reset release. Outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_sdram_cmd_gen;
    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;

    localparam logic [4:0] NOP  = 5'b10111;
    localparam logic [4:0] ACT  = 5'b10011;
    localparam logic [4:0] RD   = 5'b10101;
    localparam logic [4:0] WR   = 5'b10100;
    localparam logic [4:0] PRE  = 5'b10010;
    localparam logic [4:0] AREF = 5'b10001;
    localparam logic [4:0] LMR  = 5'b10000;

    localparam logic [23:0] TEST_ADDR = {2'd1, 13'h0ABC, 9'h015};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_cmd_gen_if #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus_a ();
    sdram_cmd_gen_if #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus_b ();

    sdram_cmd_gen #(.T_POWERUP(10), .REF_INTERVAL(780), .AUTO_PRE(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sdram_cmd_gen #(.T_POWERUP(10), .REF_INTERVAL(50), .AUTO_PRE(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] pins_a();
        return 32'({bus_a.sdram_cke, bus_a.sdram_csn, bus_a.sdram_rasn, bus_a.sdram_casn,
                    bus_a.sdram_wen, bus_a.sdram_ba, bus_a.sdram_addr});
    endfunction

    function automatic logic [31:0] pins_b();
        return 32'({bus_b.sdram_cke, bus_b.sdram_csn, bus_b.sdram_rasn, bus_b.sdram_casn,
                    bus_b.sdram_wen, bus_b.sdram_ba, bus_b.sdram_addr});
    endfunction

    function automatic logic [31:0] pins(input logic [4:0] c, input logic [1:0] ba, input logic [12:0] a);
        return 32'({c, ba, a});
    endfunction

    // {req_ready, done, init_done, rd_strobe, wr_strobe}
    function automatic logic [31:0] status_a();
        return 32'({bus_a.req_ready, bus_a.done, bus_a.init_done, bus_a.rd_strobe, bus_a.wr_strobe});
    endfunction

    function automatic logic [31:0] status_b();
        return 32'({bus_b.req_ready, bus_b.done, bus_b.init_done, bus_b.rd_strobe, bus_b.wr_strobe});
    endfunction

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    // Expected init on both instances after release:
    // 9 more NOPs, PRECHARGE A10 at k=10, A_REF at k=13 and k=21,
    // LMR 0x033 at k=29, and IDLE with init_done at k=32.
    task automatic check_init();
        for (int i = 1; i <= 32; i++) begin
            logic [4:0]  c;
            logic [12:0] a;
            tick();
            c = NOP;
            a = 13'h0000;
            if (i == 10) begin
                c = PRE;
                a = 13'h0400;
            end else if (i == 13 || i == 21) begin
                c = AREF;
            end else if (i == 29) begin
                c = LMR;
                a = 13'h0033;
            end
            chk("init_pins_a", pins_a(), pins(c, 2'd0, a));
            chk("init_pins_b", pins_b(), pins(c, 2'd0, a));
            chk("init_done_a", 32'(bus_a.init_done), 32'(i == 32));
            chk("init_done_b", 32'(bus_b.init_done), 32'(i == 32));
            chk("init_ready_a", 32'(bus_a.req_ready), 32'(i == 32));
            chk("init_nodone_a", 32'(bus_a.done), 32'(0));
        end
    endtask

    initial begin
        int          pend_m;
        int          pend_prev;
        int          last_aref;
        int          aref_cnt;
        int          exp_cnt;
        logic [4:0]  c;
        logic [1:0]  ba;
        logic [12:0] a;

        bus_a.req_valid = 1'b0;
        bus_a.req_wr    = 1'b0;
        bus_a.req_addr  = '0;
        bus_b.req_valid = 1'b0;
        bus_b.req_wr    = 1'b0;
        bus_b.req_addr  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pins_a", pins_a(), pins(NOP, 2'd0, 13'h0));
        chk("rst_pins_b", pins_b(), pins(NOP, 2'd0, 13'h0));
        chk("rst_status_a", status_a(), 32'(0));
        chk("rst_status_b", status_b(), 32'(0));
        rst = 1'b0;
        k   = 0;

        check_init();
        $display("txn init k=%0d init_done_a=%0b init_done_b=%0b", k, bus_a.init_done, bus_b.init_done);

        // Read on A (auto-precharge); accept at k=32
        bus_a.req_valid = 1'b1;
        bus_a.req_wr    = 1'b0;
        bus_a.req_addr  = TEST_ADDR;
        chk("rd_ready_at_accept", 32'(bus_a.req_ready), 32'(1));
        for (int r = 1; r <= 17; r++) begin
            tick();
            if (r == 1) bus_a.req_valid = 1'b0;
            c = NOP; ba = 2'd0; a = 13'h0;
            if (r == 1) begin c = ACT; ba = 2'd1; a = 13'h0ABC; end
            else if (r == 3) begin c = RD; ba = 2'd1; a = 13'h0415; end
            chk("rd_pins", pins_a(), pins(c, ba, a));
            chk("rd_strobe", 32'(bus_a.rd_strobe), 32'(r >= 6 && r <= 13));
            chk("rd_done", 32'(bus_a.done), 32'(r == 16));
            chk("rd_ready", 32'(bus_a.req_ready), 32'(r >= 16));
        end
        $display("txn read a addr=0x%06h k=%0d", TEST_ADDR, k);

        // Write on B (explicit precharge); accept at k=49
        bus_b.req_valid = 1'b1;
        bus_b.req_wr    = 1'b1;
        bus_b.req_addr  = TEST_ADDR;
        for (int r = 1; r <= 17; r++) begin
            tick();
            if (r == 1) bus_b.req_valid = 1'b0;
            c = NOP; ba = 2'd0; a = 13'h0;
            if (r == 1) begin c = ACT; ba = 2'd1; a = 13'h0ABC; end
            else if (r == 3) begin c = WR; ba = 2'd1; a = 13'h0015; end
            else if (r == 13) begin c = PRE; ba = 2'd1; a = 13'h0000; end
            chk("wr_pins", pins_b(), pins(c, ba, a));
            chk("wr_strobe", 32'(bus_b.wr_strobe), 32'(r >= 3 && r <= 10));
            chk("wr_done", 32'(bus_b.done), 32'(r == 16));
        end
        $display("txn write b addr=0x%06h k=%0d", TEST_ADDR, k);

        // B: req_valid held from k=77. Refresh timer expires at k=82, 132, ...
        while (k < 77) tick();
        bus_b.req_valid = 1'b1;
        pend_m    = 0;
        last_aref = -1000;
        aref_cnt  = 0;
        exp_cnt   = 0;
        while (k < 400) begin
            tick();
            c = {bus_b.sdram_cke, bus_b.sdram_csn, bus_b.sdram_rasn, bus_b.sdram_casn, bus_b.sdram_wen};
            pend_prev = pend_m;
            if (c == AREF) begin
                chk("aref_only_when_pending", 32'(pend_prev), 32'(1));
                aref_cnt++;
                last_aref = k;
                pend_m    = 0;
                $display("txn refresh b k=%0d", k);
            end
            if (c == ACT) begin
                chk("act_not_while_pending", 32'(pend_prev), 32'(0));
                chk("act_outside_trfc", 32'(k - last_aref >= 9), 32'(1));
            end
            if (k >= 82 && (k - 82) % 50 == 0) begin
                pend_m = 1;
                exp_cnt++;
            end
            if (k == 80) chk("burst_write_cmd", pins_b(), pins(WR, 2'd1, 13'h0015));
            if (k == 82) chk("burst_strobe_at_expiry", 32'(bus_b.wr_strobe), 32'(1));
            if (k == 87) chk("burst_strobe_last", 32'(bus_b.wr_strobe), 32'(1));
            if (k == 88) chk("burst_strobe_off", 32'(bus_b.wr_strobe), 32'(0));
            if (k == 90) chk("burst_precharge", pins_b(), pins(PRE, 2'd1, 13'h0));
            if (k == 93) chk("burst_done_ready", 32'({bus_b.done, bus_b.req_ready}), 32'(2'b10));
            if (k == 94) chk("burst_aref_first", pins_b(), pins(AREF, 2'd0, 13'h0));
            if (k == 102) chk("post_ref_ready", 32'(bus_b.req_ready), 32'(1));
            if (k == 103) chk("post_ref_act", pins_b(), pins(ACT, 2'd1, 13'h0ABC));
        end
        bus_b.req_valid = 1'b0;
        chk("refresh_count", 32'(aref_cnt + pend_m), 32'(exp_cnt));
        $display("txn refresh window b arefs=%0d expiries=%0d", aref_cnt, exp_cnt);

        // A: read, then reset in the middle of RDATA
        bus_a.req_valid = 1'b1;
        bus_a.req_wr    = 1'b0;
        bus_a.req_addr  = TEST_ADDR;
        for (int r = 1; r <= 8; r++) begin
            tick();
            if (r == 1) begin
                bus_a.req_valid = 1'b0;
                chk("rst_rd_act", pins_a(), pins(ACT, 2'd1, 13'h0ABC));
            end
            chk("rst_rd_strobe", 32'(bus_a.rd_strobe), 32'(r >= 6));
        end
        rst = 1'b1;
        #1;
        chk("async_rst_pins_a", pins_a(), pins(NOP, 2'd0, 13'h0));
        chk("async_rst_status_a", status_a(), 32'(0));
        chk("async_rst_pins_b", pins_b(), pins(NOP, 2'd0, 13'h0));
        tick();
        chk("rst_hold_pins_a", pins_a(), pins(NOP, 2'd0, 13'h0));
        chk("rst_hold_done_a", 32'(bus_a.done), 32'(0));
        rst = 1'b0;
        k   = 0;
        $display("txn reset during rdata a");
        check_init();
        $display("txn reinit k=%0d init_done_a=%0b", k, bus_a.init_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
